// File: rtl/led_matrix_scan.sv
// Purpose: fetches one 8-cell row of the frame buffer over the shared bus and scans the 8x8 dual-colour LED matrix row by row.
// Latency: first row is lit BLANK cycles after a 9-cycle prime fetch; every LED output is registered.
// Backpressure: a withheld bus_gnt stalls the column fetch, and the lit row stays on until its successor row is buffered.
module led_matrix_scan #(
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       mem_rd,
    output logic [5:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [7:0] led_row,
    output logic [7:0] led_r_col,
    output logic [7:0] led_g_col,
    output logic       frame_start
);

    // One counter serves both the blanking gap and the dwell time.
    localparam int CW = $clog2(DWELL + BLANK + 1);

    typedef enum logic [1:0] {
        ST_PRIME,
        ST_BLANK,
        ST_SHOW
    } state_t;

    // ------------------------------------------------------------------
    // Fetch engine state
    // ------------------------------------------------------------------
    logic [2:0] fetch_row_q;    // row currently being (or last) fetched
    logic [2:0] col_q;          // next column to issue
    logic       rd_pend_q;      // a read was issued last cycle, data arrives now
    logic [2:0] rd_col_q;       // column of that pending read
    logic       fetch_done_q;   // shadow buffer holds a complete row
    logic [7:0] shadow_r_q;
    logic [7:0] shadow_g_q;

    // ------------------------------------------------------------------
    // Display state
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0] disp_row_q;
    logic [2:0] disp_row_d;
    logic [7:0] active_r_q;
    logic [7:0] active_g_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [7:0] shadow_r_nx;
    logic [7:0] shadow_g_nx;
    logic       capture_last;   // column 7 data is being captured this cycle
    logic       done_now;       // row complete, counting the capture in progress
    logic       fetch_busy;
    logic       start_fetch;
    logic [2:0] start_row;
    logic       swap;
    logic [7:0] led_row_d;
    logic [7:0] led_r_d;
    logic [7:0] led_g_d;
    logic       frame_start_d;

    // The read strobe follows the grant directly so a withheld grant never issues a read.
    assign mem_rd       = bus_req && bus_gnt;
    assign mem_addr     = {fetch_row_q, col_q};
    assign capture_last = rd_pend_q && (rd_col_q == 3'd7);
    assign done_now     = fetch_done_q || capture_last;
    assign fetch_busy   = bus_req || rd_pend_q;

    // Shadow row as it will look after this cycle's capture; a swap copies this so the last column is not lost.
    always_comb begin
        shadow_r_nx = shadow_r_q;
        shadow_g_nx = shadow_g_q;
        if (rd_pend_q) begin
            shadow_r_nx[rd_col_q] = mem_data[0];
            shadow_g_nx[rd_col_q] = mem_data[1];
        end
    end

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        disp_row_d    = disp_row_q;
        swap          = 1'b0;
        start_fetch   = 1'b0;
        start_row     = fetch_row_q;
        led_row_d     = 8'hFF;
        led_r_d       = 8'h00;
        led_g_d       = 8'h00;
        frame_start_d = 1'b0;

        case (state_q)
            ST_PRIME: begin
                // Kick off the row-0 fetch once after reset, then wait for it.
                if (!fetch_busy && !fetch_done_q) begin
                    start_fetch = 1'b1;
                    start_row   = fetch_row_q;
                end
                if (done_now) begin
                    swap = 1'b1;
                end
            end

            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d   = ST_SHOW;
                    cnt_d     = '0;
                    led_row_d = ~(8'd1 << disp_row_q);
                    led_r_d   = active_r_q;
                    led_g_d   = active_g_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHOW: begin
                led_row_d = ~(8'd1 << disp_row_q);
                led_r_d   = active_r_q;
                led_g_d   = active_g_q;
                // Count saturates at the dwell limit; the row stays lit until the next row is buffered.
                if (cnt_q < CW'(DWELL - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (done_now) begin
                    swap = 1'b1;
                end
            end

            default: begin
                state_d = ST_PRIME;
            end
        endcase

        // Swap: promote the buffered row, blank the pins and prefetch the following row.
        if (swap) begin
            state_d       = ST_BLANK;
            cnt_d         = '0;
            disp_row_d    = fetch_row_q;
            start_fetch   = 1'b1;
            start_row     = fetch_row_q + 3'd1;
            frame_start_d = (fetch_row_q == 3'd0);
            led_row_d     = 8'hFF;
            led_r_d       = 8'h00;
            led_g_d       = 8'h00;
        end
    end

    // Fetch engine: issue columns 0..7 on granted cycles and capture each cell one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req      <= 1'b0;
            col_q        <= 3'd0;
            fetch_row_q  <= 3'd0;
            rd_pend_q    <= 1'b0;
            rd_col_q     <= 3'd0;
            fetch_done_q <= 1'b0;
            shadow_r_q   <= 8'h00;
            shadow_g_q   <= 8'h00;
        end else begin
            shadow_r_q <= shadow_r_nx;
            shadow_g_q <= shadow_g_nx;
            rd_pend_q  <= mem_rd;
            rd_col_q   <= col_q;
            if (start_fetch) begin
                bus_req      <= 1'b1;
                col_q        <= 3'd0;
                fetch_row_q  <= start_row;
                fetch_done_q <= 1'b0;
            end else begin
                if (mem_rd) begin
                    col_q <= col_q + 3'd1;
                    if (col_q == 3'd7) begin
                        bus_req <= 1'b0;
                    end
                end
                if (capture_last) begin
                    fetch_done_q <= 1'b1;
                end
            end
        end
    end

    // Scan sequencer registers, active row buffer and registered LED pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PRIME;
            cnt_q       <= '0;
            disp_row_q  <= 3'd7;
            active_r_q  <= 8'h00;
            active_g_q  <= 8'h00;
            led_row     <= 8'hFF;
            led_r_col   <= 8'h00;
            led_g_col   <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            disp_row_q  <= disp_row_d;
            led_row     <= led_row_d;
            led_r_col   <= led_r_d;
            led_g_col   <= led_g_d;
            frame_start <= frame_start_d;
            if (swap) begin
                active_r_q <= shadow_r_nx;
                active_g_q <= shadow_g_nx;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Purpose: directed bench for led_matrix_scan with a frame-schedule model and a bus protocol monitor.
// Latency: outputs sampled on the falling edge; inputs driven 2 time units after the rising edge.
// Backpressure: bus_gnt withheld and toggled to exercise fetch stalls and extended rows.
module tb_led_matrix_scan;

    localparam int TB_DWELL = 16;
    localparam int TB_BLANK = 2;
    localparam int ROW_PER  = TB_DWELL + TB_BLANK;
    localparam int PRIME_T  = 9;

    logic       clk;
    logic       reset;
    logic       bus_req;
    logic       bus_gnt;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [1:0] mem_data;
    logic [7:0] led_row;
    logic [7:0] led_r_col;
    logic [7:0] led_g_col;
    logic       frame_start;

    logic [1:0] mem [64];

    int         total;
    int         bad;
    int         rel;
    int         phase;
    int         last_fs;
    int         tog_cnt;
    logic [2:0] exp_col;
    logic       rd_s;
    logic [5:0] addr_s;

    led_matrix_scan #(.DWELL(TB_DWELL), .BLANK(TB_BLANK)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .led_row     (led_row),
        .led_r_col   (led_r_col),
        .led_g_col   (led_g_col),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (phase %0d cycle %0d)", name, act, exp, phase, rel);
        end
    endtask

    // Cycle index relative to the first rising edge that samples reset low.
    always @(posedge clk) begin
        if (reset) rel = -1;
        else       rel = rel + 1;
    end

    // Memory: sample the read at mid-cycle, return data just after the next rising edge.
    always @(negedge clk) begin
        rd_s   = mem_rd;
        addr_s = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        if (rd_s) mem_data = mem[addr_s];
        else      mem_data = 2'b11;
    end

    // Expected outputs with a constant grant, from the frame timing arithmetic.
    task automatic model_check(input int t);
        logic [7:0] er;
        logic [7:0] erc;
        logic [7:0] egc;
        logic       efs;
        logic       ereq;
        logic [5:0] ea;
        int u;
        int p;
        int row;
        er  = 8'hFF;
        erc = 8'h00;
        egc = 8'h00;
        efs = 1'b0;
        if (t < PRIME_T) begin
            ereq = (t < 8);
            ea   = 6'(t);
        end else begin
            u    = t - PRIME_T;
            p    = u % ROW_PER;
            row  = (u / ROW_PER) % 8;
            efs  = (p == 0) && (row == 0);
            ereq = (p < 8);
            ea   = 6'(((row + 1) % 8) * 8 + p);
            if (p >= TB_BLANK) begin
                er = ~(8'd1 << row);
                for (int c = 0; c < 8; c++) begin
                    erc[c] = mem[row * 8 + c][0];
                    egc[c] = mem[row * 8 + c][1];
                end
            end
        end
        check("model_led_row", led_row, er);
        check("model_led_r", led_r_col, erc);
        check("model_led_g", led_g_col, egc);
        check("model_frame_start", frame_start, efs);
        check("model_bus_req", bus_req, ereq);
        check("model_mem_rd", mem_rd, ereq);
        if (ereq) check("model_mem_addr", mem_addr, ea);
    endtask

    task automatic reset_checks();
        check("rst_led_row", led_row, 8'hFF);
        check("rst_led_r", led_r_col, 8'h00);
        check("rst_led_g", led_g_col, 8'h00);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_mem_addr", mem_addr, 6'd0);
    endtask

    // Single compare process: reset values, schedule model, bus protocol and pinned literals.
    always @(negedge clk) begin
        if (phase == 0 && reset) reset_checks();
        if (phase == 3 && rel == -1) reset_checks();
        if (!reset && rel >= 0) begin
            if (mem_rd) begin
                check("rd_only_on_gnt", bus_gnt, 1'b1);
                check("rd_col_order", mem_addr[2:0], exp_col);
                exp_col = exp_col + 3'd1;
                if (phase == 2 && rel >= 76 && rel <= 91) tog_cnt++;
            end
            if (phase == 1 || phase == 4 || (phase == 2 && rel <= 26)) model_check(rel);
            if (phase == 1 && frame_start) begin
                if (last_fs >= 0) check("frame_period", rel - last_fs, 144);
                last_fs = rel;
            end
            case (phase)
                1: begin
                    if (rel == 9) check("p1_fs_at_9", frame_start, 1'b1);
                    if (rel == 11) begin
                        check("p1_row0_sel", led_row, 8'hFE);
                        check("p1_row0_r", led_r_col, 8'b0011_0101);
                        check("p1_row0_g", led_g_col, 8'b0100_0110);
                    end
                    if (rel == 65) check("p1_row3_r", led_r_col, 8'h08);
                    if (rel == 137) begin
                        check("p1_row7_sel", led_row, 8'h7F);
                        check("p1_row7_r", led_r_col, 8'h80);
                    end
                    if (rel == 155) check("p1_wrap_row0", led_row, 8'hFE);
                end
                2: begin
                    if (rel == 45) check("p2_row1_extended", led_row, 8'hFD);
                    if (rel == 50) begin
                        check("p2_req_held", bus_req, 1'b1);
                        check("p2_no_rd", mem_rd, 1'b0);
                    end
                    if (rel == 67) begin
                        check("p2_resume_rd", mem_rd, 1'b1);
                        check("p2_resume_addr", mem_addr, 6'd16);
                    end
                    if (rel == 75) begin
                        check("p2_row1_last", led_row, 8'hFD);
                        check("p2_req_dropped", bus_req, 1'b0);
                    end
                    if (rel == 76) check("p2_blank_row2", led_row, 8'hFF);
                    if (rel == 78) begin
                        check("p2_row2_sel", led_row, 8'hFB);
                        check("p2_row2_r", led_r_col, 8'h04);
                    end
                    if (rel == 92) check("p2_toggle_issues", tog_cnt, 8);
                    if (rel == 96) begin
                        check("p2_row3_sel", led_row, 8'hF7);
                        check("p2_row3_r", led_r_col, 8'h08);
                        check("p2_row3_g", led_g_col, 8'h00);
                    end
                    if (rel == 117) check("p2_row4_sel", led_row, 8'hEF);
                end
                4: begin
                    if (rel == 0) check("p4_refetch_addr0", mem_addr, 6'd0);
                    if (rel == 9) check("p4_fs_at_9", frame_start, 1'b1);
                end
                default: ;
            endcase
        end
        if (reset) exp_col = 3'd0;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rel      = -1;
        phase    = 0;
        last_fs  = -1;
        tog_cnt  = 0;
        exp_col  = 3'd0;
        rd_s     = 1'b0;
        addr_s   = 6'd0;
        mem_data = 2'b00;
        reset    = 1'b1;
        bus_gnt  = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r * 8 + c] = (c == r) ? 2'b01 : 2'b00;
        mem[0] = 2'b01; mem[1] = 2'b10; mem[2] = 2'b11; mem[3] = 2'b00;
        mem[4] = 2'b01; mem[5] = 2'b01; mem[6] = 2'b10; mem[7] = 2'b00;

        // Three reset edges, then a long run with constant grant.
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        phase = 1;
        for (int i = 0; i < 400 && rel < 320; i++) step();

        // Fresh start for the grant-withheld and grant-toggling runs.
        phase = 9;
        reset = 1'b1;
        step();
        reset = 1'b0;
        phase = 2;
        for (int i = 0; i < 200 && rel < 118; i++) begin
            step();
            if (rel >= 27 && rel <= 66)      bus_gnt = 1'b0;
            else if (rel >= 76 && rel <= 91) bus_gnt = (rel % 2 == 0);
            else                             bus_gnt = 1'b1;
        end

        // One-cycle reset while row 4 is lit.
        bus_gnt = 1'b1;
        reset   = 1'b1;
        phase   = 3;
        step();
        reset = 1'b0;
        phase = 4;
        for (int i = 0; i < 100 && rel < 40; i++) step();

        phase = 9;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Downstream display stage for the 8x8 dual-colour LED matrix.
- Reads the 64-cell game frame buffer (6-bit address, 2-bit cell) over the shared memory bus using a request/grant handshake.
- Double-buffers one row, then time-multiplexes the rows onto the row/red/green pins with a blanking gap between rows.

Parameters:
- DWELL, 1000: cycles each row is lit (minimum 16).
- BLANK, 2: all-off cycles before each row is lit (minimum 1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bus_req  output  1  request for the shared memory bus.
- bus_gnt  input  1  bus grant from the arbiter; only valid while bus_req=1.
- mem_rd  output  1  read strobe; asserted only when bus_req&&bus_gnt.
- mem_addr  output  6  cell address = {row[2:0], col[2:0]}.
- mem_data  input  2  cell data, valid the cycle after mem_rd. Bit0=red, bit1=green (00 off, 01 red, 10 green, 11 yellow).
- led_row  output  8  row select, active-low one-hot; bit r = row r.
- led_r_col  output  8  red columns, active-high; bit c = column c.
- led_g_col  output  8  green columns, active-high.
- frame_start  output  1  one-cycle pulse on the first BLANK cycle of row 0.

Behaviour:
- Reset values:
  - led_row=8'hFF; led_r_col=0, led_g_col=0.
  - bus_req=0, mem_rd=0, mem_addr=0, frame_start=0.
  - Shadow and active row buffers cleared; fetch row=0; display row=7.
  - State=PRIME.
- Reset asserted mid-operation: all of the above applies on the next edge. Any in-flight read data is discarded.
- Fetch engine (runs independently of display):
  - bus_req goes high when a fetch starts.
  - In each cycle with bus_req&&bus_gnt: mem_rd=1, mem_addr={fetch_row, col}, col increments 0..7.
  - mem_data is captured one cycle later into shadow bit [col].
  - If bus_gnt is low, col holds and mem_rd=0. A read already issued is still captured on the following cycle.
  - bus_req drops in the cycle after col 7 is issued. fetch_done is set when col 7 data is captured.
  - Minimum fetch time: 9 cycles.
- States:
  - PRIME: fetch row 0. On fetch_done, copy shadow to active, display row=0, go to BLANK.
  - BLANK:
    - Lasts exactly BLANK cycles; led_row=FF and columns=0.
    - On the first BLANK cycle, the fetch of (display_row+1) mod 8 starts and fetch_done clears.
    - frame_start=1 on that first cycle if display_row==0.
    - Then go to SHOW.
  - SHOW:
    - led_row = ~(1<<display_row); led_r_col/led_g_col = active buffer.
    - After DWELL cycles, if fetch_done: copy shadow to active, display_row = fetch_row, go to BLANK.
    - If fetch is not done, SHOW is extended (same row stays lit) until the cycle after fetch_done, then swap.
- Row wrap: 7 -> 0. Fetch row is always display row + 1 mod 8.
- Timing with bus_gnt held at 1:
  - Reset released at cycle 0: addresses issued cycles 0-7, swap at cycle 9.
  - frame_start pulses at cycle 9.
  - Row 0 lit over cycles 9+BLANK to 9+BLANK+DWELL-1.
  - Steady-state row period = BLANK+DWELL; frame period = 8*(BLANK+DWELL).
- Memory content changing mid-fetch: whatever is read is displayed; there is no coherency guarantee within a row.
- Outputs are registered; no combinational path from inputs to LED pins.

Test Plan:
- Reset hold: assert reset for 3 cycles in any state -> led_row=FF, cols=00, bus_req=0, mem_rd=0 on the cycle after the first reset edge.
- Prime/fetch, with gnt=1, DWELL=16, BLANK=2, memory row0 = cols {01,10,11,00,01,01,10,00}:
  - mem_addr 0..7 appear on cycles 0-7.
  - frame_start at cycle 9.
  - At cycle 11: led_row=FE, led_r_col=8'b0011_0101, led_g_col=8'b0100_0110.
- Full frame, with constant gnt and distinct row patterns (row r cell = red only at col r):
  - Each row r is lit with led_r_col=1<<r.
  - frame_start period is 144 cycles.
  - Row 7 is followed by row 0.
- Grant withheld, with gnt=0 from the start of row 1 BLANK for 40 cycles:
  - Row 1 SHOW extends beyond 16 cycles and stays lit.
  - After gnt returns: 9 cycles of fetch, then the swap to row 2.
- Grant toggling, with gnt alternating 1/0 each cycle during a fetch:
  - mem_rd only occurs on gnt=1 cycles; addresses are issued in order with no skipped or repeated column.
  - Shadow data matches memory.
- Reset mid-SHOW of row 4, asserted 1 cycle:
  - Next cycle: LEDs blank and state is PRIME.
  - Refetch starts at address 0; the next frame_start occurs 9 cycles after reset release.
